// File: rtl/dc_video_reconfig_seq.sv
// dc_video_reconfig_seq
//   Qualifies the asynchronous MCU mode byte, decodes it to a video config ID
//   and sequences a safe reconfiguration: blank video, 4-phase req/ack
//   handshake with the PLL/timing reconfig logic, settle, unblank.
//
//   Optional feature macro: DC_RECONF_TIMEOUT_EN
//     defined   : REQ gives up after TIMEOUT_CYCLES without ack, pulses
//                 timeout_err and proceeds to SETTLE (new config retained).
//     undefined : REQ waits for ack indefinitely; timeout_err is tied low.
module dc_video_reconfig_seq #(
  parameter int DATA_WIDTH     = 8,
  parameter int CFG_W          = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int BLANK_CYCLES   = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  reconf_ack,
  output logic                  reconf_req,
  output logic                  video_blank,
  output logic [CFG_W-1:0]      config_id,
  output logic                  force_vga,
  output logic                  busy,
  output logic                  invalid_code,
  output logic                  timeout_err
);

  // Elaboration-time guard on the parameter ranges the design relies on.
  if (DATA_WIDTH < 8 || CFG_W < 4 || STABLE_CYCLES < 1 || STABLE_CYCLES > 255 ||
      BLANK_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dc_video_reconfig_seq: parameter out of range");
  end

  // Sequencing counter is shared by BLANK, SETTLE and (optionally) REQ.
`ifdef DC_RECONF_TIMEOUT_EN
  localparam int SEQ_MAX_A = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
  localparam int SEQ_MAX   = (SEQ_MAX_A > TIMEOUT_CYCLES) ? SEQ_MAX_A : TIMEOUT_CYCLES;
`else
  localparam int SEQ_MAX   = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
`endif
  localparam int SEQ_W = $clog2(SEQ_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK   = 3'd1,
    REQ     = 3'd2,
    ACK_LOW = 3'd3,
    SETTLE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [CFG_W-1:0] id;
  } dec_t;

  // Mode code to config ID; anything not listed is undecodable.
  function automatic dec_t decode(input logic [6:0] code);
    dec_t d;
    d.valid = 1'b1;
    d.id    = '0;
    case (code)
      7'h00:                      d.id = CFG_W'(0);   // 1080P
      7'h01:                      d.id = CFG_W'(1);   // 960P
      7'h02:                      d.id = CFG_W'(2);   // 480P
      7'h03:                      d.id = CFG_W'(3);   // VGA
      7'h08, 7'h09, 7'h0A, 7'h0B: d.id = CFG_W'(4);   // 576P
      7'h10:                      d.id = CFG_W'(5);   // 240P variants
      7'h11:                      d.id = CFG_W'(6);
      7'h12:                      d.id = CFG_W'(7);
      7'h13:                      d.id = CFG_W'(8);
      7'h20, 7'h21, 7'h22, 7'h23: d.id = CFG_W'(9);   // 480I
      7'h40, 7'h41, 7'h42, 7'h43: d.id = CFG_W'(10);  // 576I
      default:                    d.valid = 1'b0;
    endcase
    return d;
  endfunction

  logic [7:0]       sync1;
  logic [7:0]       s;
  logic [7:0]       stab_cnt;
  logic             qual_done;
  logic             qualify;
  dec_t             dec;
  state_t           state;
  logic [SEQ_W-1:0] seq_cnt;
  logic [CFG_W-1:0] tgt_id;
  logic             tgt_vga;

  // Bits above the mode byte carry no meaning and are not synchronised.
  // NOTE: only the low byte is brought across; the 2-flop chain is the sole
  // path from the MCU domain, so nothing downstream may look at data_in.

  // Two-flop synchroniser plus the stability counter on the synced value.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      s         <= '0;
      stab_cnt  <= '0;
      qual_done <= 1'b0;
    end else begin
      sync1 <= data_in[7:0];
      s     <= sync1;
      // sync1 is the next value of s, so a mismatch means s is about to change.
      if (sync1 != s) begin
        stab_cnt  <= '0;
        qual_done <= 1'b0;
      end else begin
        if (stab_cnt != 8'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 8'd1;
        if (qualify) qual_done <= 1'b1;
      end
    end
  end

  // A stable code is consumed once; it cannot re-qualify until s changes.
  assign qualify = (state == IDLE) && (stab_cnt == 8'(STABLE_CYCLES)) && !qual_done;
  assign dec     = decode(s[6:0]);

  // Reconfiguration sequencer with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      seq_cnt      <= '0;
      tgt_id       <= '0;
      tgt_vga      <= 1'b0;
      config_id    <= '0;
      force_vga    <= 1'b0;
      reconf_req   <= 1'b0;
      video_blank  <= 1'b0;
      busy         <= 1'b0;
      invalid_code <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by the
      // branch that fires them, which guarantees single-cycle width.
      invalid_code <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (qualify) begin
            if (!dec.valid) begin
              invalid_code <= 1'b1;
            end else if ({dec.id, s[7]} != {config_id, force_vga}) begin
              tgt_id      <= dec.id;
              tgt_vga     <= s[7];
              state       <= BLANK;
              video_blank <= 1'b1;
              busy        <= 1'b1;
              seq_cnt     <= '0;
            end
          end
        end

        BLANK: begin
          if (seq_cnt == SEQ_W'(BLANK_CYCLES - 1)) begin
            state      <= REQ;
            reconf_req <= 1'b1;
            config_id  <= tgt_id;
            force_vga  <= tgt_vga;
            seq_cnt    <= '0;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end

        REQ: begin
          if (reconf_ack) begin
            reconf_req <= 1'b0;
            state      <= ACK_LOW;
          end
`ifdef DC_RECONF_TIMEOUT_EN
          else if (seq_cnt == SEQ_W'(TIMEOUT_CYCLES - 1)) begin
            reconf_req  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= SETTLE;
            seq_cnt     <= '0;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
`endif
        end

        ACK_LOW: begin
          if (!reconf_ack) begin
            state   <= SETTLE;
            seq_cnt <= '0;
          end
        end

        SETTLE: begin
          if (seq_cnt == SEQ_W'(SETTLE_CYCLES - 1)) begin
            state       <= IDLE;
            video_blank <= 1'b0;
            busy        <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          reconf_req  <= 1'b0;
          video_blank <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_video_reconfig_seq.sv
// Directed testbench for dc_video_reconfig_seq (default parameters).
// Build with +define+DC_RECONF_TIMEOUT_EN to exercise the ack timeout.
module tb_dc_video_reconfig_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       reconf_ack;
  logic       reconf_req;
  logic       video_blank;
  logic [3:0] config_id;
  logic       force_vga;
  logic       busy;
  logic       invalid_code;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  dc_video_reconfig_seq dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .reconf_ack   (reconf_ack),
    .reconf_req   (reconf_req),
    .video_blank  (video_blank),
    .config_id    (config_id),
    .force_vga    (force_vga),
    .busy         (busy),
    .invalid_code (invalid_code),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic activity;
    reset_n    = 1'b0;
    data_in    = 8'h00;
    reconf_ack = 1'b0;
    step(2);
    checks++;
    if ({reconf_req, video_blank, busy, invalid_code, timeout_err, force_vga, config_id} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b blank=%b busy=%b inv=%b to=%b vga=%b id=%0d expected all 0",
               reconf_req, video_blank, busy, invalid_code, timeout_err, force_vga, config_id);
    end
    reset_n  = 1'b1;
    activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      activity |= reconf_req | video_blank | busy | invalid_code;
    end
    checks++;
    if (activity !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: activity=%b expected 0", activity);
    end
    checks++;
    if ({config_id, force_vga, busy} !== 6'd0) begin
      errors++;
      $display("FAIL idle_state: id=%0d vga=%b busy=%b expected 0/0/0", config_id, force_vga, busy);
    end
  endtask

  task automatic test_mode_change;
    data_in = 8'h11;                    // change launched after edge 0
    step(6);
    checks++;
    if (video_blank !== 1'b0) begin
      errors++;
      $display("FAIL blank_early: blank=%b expected 0 at cycle 6", video_blank);
    end
    step(1);                            // edge 7
    checks++;
    if ({video_blank, busy, reconf_req} !== 3'b110) begin
      errors++;
      $display("FAIL blank_latency: blank/busy/req=%b%b%b expected 110 at cycle 7",
               video_blank, busy, reconf_req);
    end
    step(15);                           // edge 22
    checks++;
    if ({video_blank, reconf_req} !== 2'b10) begin
      errors++;
      $display("FAIL req_early: blank/req=%b%b expected 10", video_blank, reconf_req);
    end
    step(1);                            // edge 23: 16 blank cycles done
    checks++;
    if ({reconf_req, config_id, force_vga} !== {1'b1, 4'd6, 1'b0}) begin
      errors++;
      $display("FAIL req_entry: req=%b id=%0d vga=%b expected 1/6/0", reconf_req, config_id, force_vga);
    end
    step(2);
    checks++;
    if (reconf_req !== 1'b1) begin
      errors++;
      $display("FAIL req_hold: req=%b expected 1", reconf_req);
    end
    reconf_ack = 1'b1;                  // sampled 3 cycles after req rose
    step(1);
    checks++;
    if ({reconf_req, busy, video_blank} !== 3'b011) begin
      errors++;
      $display("FAIL req_drop: req/busy/blank=%b%b%b expected 011", reconf_req, busy, video_blank);
    end
    step(1);
    reconf_ack = 1'b0;                  // next edge enters SETTLE
    step(64);
    checks++;
    if ({video_blank, busy} !== 2'b11) begin
      errors++;
      $display("FAIL settle_hold: blank/busy=%b%b expected 11", video_blank, busy);
    end
    step(1);
    checks++;
    if ({video_blank, busy, config_id} !== {2'b00, 4'd6}) begin
      errors++;
      $display("FAIL settle_done: blank/busy=%b%b id=%0d expected 00/6", video_blank, busy, config_id);
    end
  endtask

  task automatic test_glitch_filter;
    logic activity;
    int   rises;
    logic prev_blank;
    activity = 1'b0;
    for (int i = 0; i < 25; i++) begin
      data_in = i[0] ? 8'h03 : 8'h02;
      step(2);
      activity |= video_blank | busy | invalid_code;
    end
    checks++;
    if (activity !== 1'b0) begin
      errors++;
      $display("FAIL glitch_quiet: activity=%b expected 0", activity);
    end
    data_in    = 8'h03;
    rises      = 0;
    prev_blank = video_blank;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (video_blank && !prev_blank) rises++;
      prev_blank = video_blank;
      reconf_ack = reconf_req;
    end
    reconf_ack = 1'b0;
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL glitch_sequences: got %0d expected 1", rises);
    end
    checks++;
    if ({config_id, force_vga, busy} !== {4'd3, 2'b00}) begin
      errors++;
      $display("FAIL glitch_result: id=%0d vga=%b busy=%b expected 3/0/0", config_id, force_vga, busy);
    end
  endtask

  task automatic test_invalid;
    int   pulses;
    logic activity;
    data_in  = 8'h85;
    pulses   = 0;
    activity = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (invalid_code) pulses++;
      activity |= video_blank | busy | reconf_req;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL invalid_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if ({activity, config_id, force_vga} !== {1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL invalid_no_change: activity=%b id=%0d vga=%b expected 0/3/0",
               activity, config_id, force_vga);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    data_in = 8'h83;
    n = 0;
    while (!reconf_req && n < 100) begin step(1); n++; end
    checks++;
    if ({reconf_req, config_id, force_vga} !== {1'b1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL vga_req: req=%b id=%0d vga=%b expected 1/3/1", reconf_req, config_id, force_vga);
    end
    reconf_ack = 1'b1;
    step(1);
    reconf_ack = 1'b0;
    step(5);                            // well inside SETTLE
    data_in = 8'h20;
    n = 0;
    while (busy && n < 100) begin step(1); n++; end
    checks++;
    if ({busy, video_blank} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: busy/blank=%b%b expected 00", busy, video_blank);
    end
    step(1);
    checks++;
    if ({video_blank, busy, config_id, force_vga} !== {2'b11, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL b2b_restart: blank/busy=%b%b id=%0d vga=%b expected 11/3/1",
               video_blank, busy, config_id, force_vga);
    end
    n = 0;
    while (!reconf_req && n < 50) begin step(1); n++; end
    checks++;
    if ({reconf_req, config_id, force_vga} !== {1'b1, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL b2b_req: req=%b id=%0d vga=%b expected 1/9/0", reconf_req, config_id, force_vga);
    end
    reconf_ack = 1'b1;
    step(1);
    reconf_ack = 1'b0;
    n = 0;
    while (busy && n < 100) begin step(1); n++; end
    checks++;
    if ({busy, video_blank, config_id} !== {2'b00, 4'd9}) begin
      errors++;
      $display("FAIL b2b_done: busy/blank=%b%b id=%0d expected 00/9", busy, video_blank, config_id);
    end
  endtask

  task automatic test_timeout;
    int   n;
    logic seen_to;
    data_in = 8'h01;
    n = 0;
    while (!reconf_req && n < 100) begin step(1); n++; end
    checks++;
    if ({reconf_req, config_id} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL to_req: req=%b id=%0d expected 1/1", reconf_req, config_id);
    end
`ifdef DC_RECONF_TIMEOUT_EN
    n = 0;
    while (reconf_req && n < 2000) begin step(1); n++; end
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL to_req_cycles: got %0d expected 1024", n);
    end
    checks++;
    if ({timeout_err, video_blank, busy} !== 3'b111) begin
      errors++;
      $display("FAIL to_pulse: err/blank/busy=%b%b%b expected 111", timeout_err, video_blank, busy);
    end
    step(1);
    checks++;
    if ({timeout_err, config_id} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL to_pulse_width: err=%b id=%0d expected 0/1", timeout_err, config_id);
    end
    seen_to = 1'b0;
    n = 0;
    while (busy && n < 100) begin step(1); n++; seen_to |= timeout_err; end
    checks++;
    if ({busy, video_blank, seen_to, n} !== {3'b000, 32'd63}) begin
      errors++;
      $display("FAIL to_settle: busy/blank/err=%b%b%b cycles=%0d expected 000/63",
               busy, video_blank, seen_to, n);
    end
`else
    seen_to = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      seen_to |= timeout_err;
    end
    checks++;
    if ({reconf_req, seen_to} !== 2'b10) begin
      errors++;
      $display("FAIL no_timeout: req=%b err=%b expected 1/0", reconf_req, seen_to);
    end
    reconf_ack = 1'b1;
    step(1);
    reconf_ack = 1'b0;
    n = 0;
    while (busy && n < 100) begin step(1); n++; end
    checks++;
    if ({busy, config_id} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL no_timeout_done: busy=%b id=%0d expected 0/1", busy, config_id);
    end
`endif
  endtask

  task automatic test_reset_mid_blank;
    int n;
    data_in = 8'h02;
    n = 0;
    while (!video_blank && n < 20) begin step(1); n++; end
    checks++;
    if (video_blank !== 1'b1) begin
      errors++;
      $display("FAIL rst_blank_start: blank=%b expected 1", video_blank);
    end
    step(3);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({reconf_req, video_blank, busy, invalid_code, timeout_err, force_vga, config_id} !== 10'd0) begin
      errors++;
      $display("FAIL rst_abort: req=%b blank=%b busy=%b inv=%b to=%b vga=%b id=%0d expected all 0",
               reconf_req, video_blank, busy, invalid_code, timeout_err, force_vga, config_id);
    end
    data_in = 8'h00;
    step(2);
    reset_n = 1'b1;
    step(20);
    checks++;
    if ({busy, video_blank, config_id} !== 6'd0) begin
      errors++;
      $display("FAIL rst_recover: busy/blank=%b%b id=%0d expected 00/0", busy, video_blank, config_id);
    end
  endtask

  initial begin
    test_reset();
    test_mode_change();
    test_glitch_filter();
    test_invalid();
    test_back_to_back();
    test_timeout();
    test_reset_mid_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
